// File: rtl/winograd_pkg.sv
// rtl/winograd_pkg.sv - shared constants, FSM state type and accumulator width for winograd_out_tf
// Accumulator width grows by GUARD_W when WINOGRAD_OUT_TF_SAT_EN is defined.
package winograd_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TILE_IN    = 4;
  localparam int TILE_OUT   = 2;
  localparam int GUARD_W    = 4;

`ifdef WINOGRAD_OUT_TF_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_COL0 = 3'd0,
    S_COL1 = 3'd1,
    S_COL2 = 3'd2,
    S_COL3 = 3'd3,
    S_OUT0 = 3'd4,
    S_OUT1 = 3'd5
  } state_t;

  // Nine-term sums need 4 extra bits to be exact before clamping.
  function automatic int acc_width(input int data_w);
    return SAT_EN ? data_w + GUARD_W : data_w;
  endfunction

endpackage

// File: rtl/winograd_out_tf_if.sv
// rtl/winograd_out_tf_if.sv - column-in / output-beat handshake bundle for winograd_out_tf
interface winograd_out_tf_if #(
  parameter int DATA_W = 32
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] m1;
  logic signed [DATA_W-1:0] m2;
  logic signed [DATA_W-1:0] m3;
  logic signed [DATA_W-1:0] m4;

  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] y1;
  logic signed [DATA_W-1:0] y2;
  logic                     tile_done;

  modport master (
    output in_valid, m1, m2, m3, m4, out_ready,
    input  in_ready, out_valid, y1, y2, tile_done
  );

  modport slave (
    input  in_valid, m1, m2, m3, m4, out_ready,
    output in_ready, out_valid, y1, y2, tile_done
  );

endinterface

// File: rtl/winograd_out_row_acc.sv
// rtl/winograd_out_row_acc.sv - one row lane of the column reduction: a0 = m0+m1+m2, a1 = m1-m2-m3
module winograd_out_row_acc #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     accept,
  input  logic [1:0]               col,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [ACC_W-1:0]  t0,
  output logic signed [ACC_W-1:0]  t1
);

  logic signed [ACC_W-1:0] dext;
  logic signed [ACC_W-1:0] a0;
  logic signed [ACC_W-1:0] a1;

  assign dext = ACC_W'(din);

  // Column 0 overwrites, so a reset mid-tile never leaks old partial sums.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a0 <= '0;
      a1 <= '0;
    end else if (accept) begin
      case (col)
        2'd0: begin
          a0 <= dext;
          a1 <= '0;
        end
        2'd1: begin
          a0 <= a0 + dext;
          a1 <= dext;
        end
        2'd2: begin
          a0 <= a0 + dext;
          a1 <= a1 - dext;
        end
        default: begin
          a1 <= a1 - dext;
        end
      endcase
    end
  end

  assign t0 = a0;
  assign t1 = a1;

endmodule

// File: rtl/winograd_out_tf.sv
// rtl/winograd_out_tf.sv - Winograd F(2,3) output transform Y = A^T*M*A, column stream in, 2 beats out
// Optional WINOGRAD_OUT_TF_SAT_EN: wide accumulation, saturated outputs and sticky sat_flag.
module winograd_out_tf
  import winograd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  winograd_out_tf_if.slave  bus
`ifdef WINOGRAD_OUT_TF_SAT_EN
  ,
  output logic              sat_flag
`endif
);

  localparam int ACC_W = acc_width(DATA_W);

  state_t state_q;
  state_t state_d;

  logic in_rdy;
  logic out_vld;
  logic done;
  logic in_acc;
  logic out_acc;
  logic [$clog2(TILE_OUT)-1:0] beat;

  logic signed [DATA_W-1:0] m_lane [TILE_IN];
  logic signed [ACC_W-1:0]  t0     [TILE_IN];
  logic signed [ACC_W-1:0]  t1     [TILE_IN];
  logic signed [ACC_W-1:0]  r      [TILE_IN];
  logic signed [ACC_W-1:0]  s1;
  logic signed [ACC_W-1:0]  s2;
  logic signed [DATA_W-1:0] c1;
  logic signed [DATA_W-1:0] c2;

  assign m_lane[0] = bus.m1;
  assign m_lane[1] = bus.m2;
  assign m_lane[2] = bus.m3;
  assign m_lane[3] = bus.m4;

  assign in_acc  = bus.in_valid & in_rdy;
  assign out_acc = out_vld & bus.out_ready;
  assign beat    = (state_q == S_OUT1);

  for (genvar i = 0; i < TILE_IN; i++) begin : g_row
    winograd_out_row_acc #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_row (
      .clk    (clk),
      .rst    (rst),
      .accept (in_acc),
      .col    (state_q[1:0]),
      .din    (m_lane[i]),
      .t0     (t0[i]),
      .t1     (t1[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_COL0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_COL0: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_d = S_COL1;
      end
      S_COL1: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_d = S_COL2;
      end
      S_COL2: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_d = S_COL3;
      end
      S_COL3: begin
        in_rdy = 1'b1;
        if (bus.in_valid) state_d = S_OUT0;
      end
      S_OUT0: begin
        out_vld = 1'b1;
        if (bus.out_ready) state_d = S_OUT1;
      end
      S_OUT1: begin
        out_vld = 1'b1;
        if (bus.out_ready) begin
          state_d = S_COL0;
          done    = 1'b1;
        end
      end
      default: begin
        state_d = S_COL0;
      end
    endcase
  end

  // Row combine: beat k picks column k of T, then applies A^T across rows.
  always_comb begin
    for (int i = 0; i < TILE_IN; i++) begin
      r[i] = beat ? t1[i] : t0[i];
    end
    s1 = r[0] + r[1] + r[2];
    s2 = r[1] - r[2] - r[3];
  end

`ifdef WINOGRAD_OUT_TF_SAT_EN
  localparam logic signed [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic sat1;
  logic sat2;

  assign sat1 = (s1 > ACC_W'(Y_MAX)) || (s1 < ACC_W'(Y_MIN));
  assign sat2 = (s2 > ACC_W'(Y_MAX)) || (s2 < ACC_W'(Y_MIN));
  assign c1   = sat1 ? (s1[ACC_W-1] ? Y_MIN : Y_MAX) : s1[DATA_W-1:0];
  assign c2   = sat2 ? (s2[ACC_W-1] ? Y_MIN : Y_MAX) : s2[DATA_W-1:0];

  // Flag only beats the consumer actually took.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_flag <= 1'b0;
    end else if (out_acc && (sat1 || sat2)) begin
      sat_flag <= 1'b1;
    end
  end
`else
  assign c1 = s1[DATA_W-1:0];
  assign c2 = s2[DATA_W-1:0];
`endif

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.tile_done = done & out_acc;
  assign bus.y1        = out_vld ? c1 : '0;
  assign bus.y2        = out_vld ? c2 : '0;

endmodule

// File: doc/winograd_out_tf.md
Name: winograd_out_tf

Overview:
- Winograd F(2,3) output transform Y = A^T·M·A. A^T = [[1,1,1,0],[0,1,-1,-1]].
- Consumes one 4x4 element-wise-product tile M, streamed one column per beat on four row lanes.
- Emits the 2x2 output tile as two beats on two lanes.
- Sits downstream of the weight-transform and element-wise-multiply stages. It is the inverse end of the weight transform: that stage expands 3 elements to 4, this stage reduces 4 to 2.

Parameters:
- DATA_W, 32, signed width of every input and output sample.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  column beat valid.
- in_ready  out  1  block accepts a column beat.
- m1, m2, m3, m4  in  DATA_W each  signed column j of M, rows 0..3.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts an output beat.
- y1, y2  out  DATA_W each  signed Y[0][k], Y[1][k] for beat k.
- tile_done  out  1  one-cycle pulse when the second output beat is accepted.
- sat_flag  out  1  sticky saturation indicator. Present only with the optional feature.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst low clears all state immediately, independent of clk).
  - State returns to S_COL0.
  - All accumulators clear to 0.
  - in_ready=1, out_valid=0, y1=y2=0, tile_done=0, sat_flag=0.
- States: S_COL0 → S_COL1 → S_COL2 → S_COL3 → S_OUT0 → S_OUT1 → S_COL0.
  - A S_COLx state advances only on an accept (in_valid & in_ready).
  - A S_OUTx state advances only on an accept (out_valid & out_ready).
- in_ready = 1 in S_COL0..S_COL3, 0 in S_OUT*.
- out_valid = 1 in S_OUT0 and S_OUT1 only. There is no overlap between tiles. Minimum 6 cycles per tile.
- Per-row accumulation (row i, with column value y arriving in column j):
  - col0: a0 = y, a1 = 0
  - col1: a0 += y, a1 = y
  - col2: a0 += y, a1 -= y
  - col3: a0 unchanged, a1 -= y
  - Net result: T[i][0] = M[i][0]+M[i][1]+M[i][2]; T[i][1] = M[i][1]-M[i][2]-M[i][3].
- Output beat k (k=0 in S_OUT0, k=1 in S_OUT1):
  - y1 = T[0][k]+T[1][k]+T[2][k]
  - y2 = T[1][k]-T[2][k]-T[3][k]
  - Computed combinationally from the registered T values.
- Latency: out_valid rises the cycle after the col3 accept.
- Arithmetic: two's complement, wrap modulo 2^DATA_W (default build). No scaling or shift.
- Backpressure: while out_valid=1 and out_ready=0, y1/y2 and the state hold stable and in_ready stays 0.
- in_valid while in S_OUT*: ignored, no accept, no side effect.
- tile_done: pulses on the S_OUT1 accept. The same cycle, the state returns to S_COL0.
- Reset mid-tile: the partial tile is discarded. The next accepted beat is treated as col0.

Optional Feature:
- Macro: WINOGRAD_OUT_TF_SAT_EN.
- Defined:
  - Accumulators and output sums are carried at DATA_W+4 bits.
  - y1/y2 saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Port sat_flag exists. It is set when any emitted beat saturates and cleared only by rst.
- Undefined:
  - DATA_W-bit wrapping arithmetic.
  - No sat_flag port.

Decomposition:
- winograd_pkg holds:
  - DATA_W default and TILE_IN=4, TILE_OUT=2.
  - The state enum (S_COL0..S_OUT1, 3 bits).
  - The saturation helper width constant (GUARD_W=4).
- Sub-module winograd_out_row_acc:
  - Per-row a0/a1 accumulator, driven by a column-index input and an accept input.
  - Instantiated four times, one per row lane.
- The top level holds the FSM, the cross-row combine and the output handshake.

Test Plan:
- Ones tile: all 16 M entries = 1, out_ready=1.
  - Beat0: y1=9, y2=-3. Beat1: y1=-3, y2=1.
  - out_valid is first high 1 cycle after the col3 accept. tile_done pulses once.
- Single impulse: M[1][1]=5, all others 0 → both beats y1=5, y2=5.
- Backpressure: ones tile, out_ready held 0 for 3 cycles in S_OUT0.
  - y1=9 and y2=-3 stable throughout; in_ready=0.
  - in_valid pulses during the stall are not accepted.
  - Beat1 follows correctly after out_ready rises.
- Mid-tile reset: accept cols 0–1 of 7s, pulse rst low asynchronously between edges. Outputs clear immediately.
  - Then send a ones tile → results identical to the ones-tile case.
- Overflow: all entries 0x7FFFFFFF, beat0 y1:
  - Without the macro: 0x7FFFFFF7 (wrap).
  - With WINOGRAD_OUT_TF_SAT_EN: 0x7FFFFFFF and sat_flag=1, held across the next tile until rst.
- Back-to-back tiles with in_valid held 1: tiles complete every 6 cycles. A random-tile scoreboard is checked against the reference A^T·M·A model.
